// File: rtl/rf_read_arbiter_pkg.sv
// Shared types and default sizing for the register-file read arbiter.
// Imported by the interface, the round-robin picker and the top.
package rf_read_arbiter_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_DW   = 32;
    localparam int DEF_AW   = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP
    } state_e;

endpackage

// File: rtl/rf_read_arbiter_if.sv
// Request/response/mux bundle between requesters and the read arbiter.
// master = requester/mux side, slave = arbiter side.
interface rf_read_arbiter_if
    import rf_read_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW
) ();

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_ready;
    logic [AW-1:0]      mux_select;
    logic [DW-1:0]      mux_data;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [DW-1:0]      rsp_data;

    modport master (
        output req_valid, req_addr, mux_data, rsp_ready,
        input  req_ready, mux_select, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, mux_data, rsp_ready,
        output req_ready, mux_select, rsp_valid, rsp_data
    );

endinterface

// File: rtl/rf_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr.
// Returns one-hot grant, its index, and whether anything was picked.
module rr_arbiter
    import rf_read_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any_grant
);

    localparam int SW = IW + 1;

    logic [SW-1:0] sum;
    logic [IW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            // wrap ptr+k back into 0..NREQ-1 without a modulo
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            idx = sum[IW-1:0];
            if (!any_grant && req[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter sharing one register-file read mux among NREQ requesters.
// Accept -> READ (mux settles on sel_q) -> RESP (registered data, held until ack).
module rf_read_arbiter
    import rf_read_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW
) (
    input  logic               clk,
    input  logic               rst,
    rf_read_arbiter_if.slave   bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [AW-1:0]   sel_q, sel_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;

    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic            accept_en;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req       (bus.req_valid),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    // no ready during reset: nothing can be accepted on a reset edge
    assign accept_en      = (state_q == IDLE) && !rst;
    assign bus.req_ready  = accept_en ? arb_grant : '0;
    assign bus.mux_select = sel_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = READ;
                    gnt_d   = arb_idx;
                    for (int i = 0; i < NREQ; i++) begin
                        if (arb_idx == IW'(i)) begin
                            sel_d = bus.req_addr[i*AW +: AW];
                        end
                    end
                end
            end
            READ: begin
                state_d     = RESP;
                rsp_data_d  = bus.mux_data;
                rsp_valid_d = NREQ'(1) << gnt_q;
            end
            RESP: begin
                if (bus.rsp_ready[gnt_q]) begin
                    state_d     = IDLE;
                    rsp_valid_d = '0;
                    rr_ptr_d    = (gnt_q == IW'(NREQ - 1))
                                ? '0 : gnt_q + IW'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            sel_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Bench for rf_read_arbiter: vector table, directed corner sequences,
// then random traffic against a transaction-level reference model.
module tb_rf_read_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] regs [16];
    int          checks;
    int          errors;

    rf_read_arbiter_if #(.NREQ(4), .DW(32), .AW(4)) bus ();

    rf_read_arbiter #(.NREQ(4), .DW(32), .AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mux_data = regs[bus.mux_select];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [15:0] addr;
        logic [3:0]  rrdy;
        logic [3:0]  e_rdy;
        logic [3:0]  e_rv;
        logic [3:0]  e_sel;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl [$];

    task automatic drive(input logic r, input logic [3:0] v,
                         input logic [15:0] a, input logic [3:0] rr);
        @(negedge clk);
        rst           = r;
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.rsp_ready = rr;
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk4(input string nm, input logic [3:0] e_rdy,
                        input logic [3:0] e_rv, input logic [3:0] e_sel,
                        input logic [31:0] e_data);
        chk({nm, "_ready"}, 32'(bus.req_ready), 32'(e_rdy));
        chk({nm, "_rvalid"}, 32'(bus.rsp_valid), 32'(e_rv));
        chk({nm, "_sel"}, 32'(bus.mux_select), 32'(e_sel));
        chk({nm, "_data"}, bus.rsp_data, e_data);
    endtask

    function automatic vec_t mk(logic r, logic [3:0] v, logic [15:0] a,
                                logic [3:0] rr, logic [3:0] er,
                                logic [3:0] ev, logic [3:0] es,
                                logic [31:0] ed);
        vec_t t;
        t = '{r, v, a, rr, er, ev, es, ed};
        return t;
    endfunction

    // reference model state
    int          owner, since, ptr, win, j;
    logic [3:0]  maddr, msel;
    logic [31:0] mdata;
    logic        r;
    logic [3:0]  v, rr, e_rdy, e_rv;
    logic [15:0] a;

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) begin
            regs[i] = (32'h1111_1111 * i) ^ 32'h5A00_0000;
        end
        regs[5] = 32'hDEAD_BEEF;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.rsp_ready = '0;

        // reset state
        drive(1, 4'b0000, 16'h0, 4'b0000);
        drive(1, 4'b0000, 16'h0, 4'b0000);
        chk4("reset", 4'b0, 4'b0, 4'h0, 32'h0);

        // single read, then full contention from reset with wrap
        tbl.push_back(mk(0, 4'b0001, 16'h0005, 4'hF, 4'b0001, 4'b0000, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'b0000, 16'h0005, 4'hF, 4'b0000, 4'b0000, 4'h5, 32'h0));
        tbl.push_back(mk(0, 4'b0000, 16'h0005, 4'hF, 4'b0000, 4'b0001, 4'h5, regs[5]));
        tbl.push_back(mk(0, 4'b0000, 16'h0005, 4'hF, 4'b0000, 4'b0000, 4'h5, regs[5]));
        tbl.push_back(mk(1, 4'b1111, 16'h4321, 4'hF, 4'b0000, 4'b0000, 4'h5, regs[5]));
        tbl.push_back(mk(0, 4'b1111, 16'h4321, 4'hF, 4'b0001, 4'b0000, 4'h0, 32'h0));
        tbl.push_back(mk(0, 4'b1111, 16'h4321, 4'hF, 4'b0000, 4'b0000, 4'h1, 32'h0));
        tbl.push_back(mk(0, 4'b1111, 16'h4321, 4'hF, 4'b0000, 4'b0001, 4'h1, regs[1]));
        tbl.push_back(mk(0, 4'b1111, 16'h4321, 4'hF, 4'b0010, 4'b0000, 4'h1, regs[1]));
        tbl.push_back(mk(0, 4'b1111, 16'h4321, 4'hF, 4'b0000, 4'b0000, 4'h2, regs[1]));
        tbl.push_back(mk(0, 4'b1111, 16'h4321, 4'hF, 4'b0000, 4'b0010, 4'h2, regs[2]));
        tbl.push_back(mk(0, 4'b1111, 16'h4321, 4'hF, 4'b0100, 4'b0000, 4'h2, regs[2]));
        tbl.push_back(mk(0, 4'b1111, 16'h4321, 4'hF, 4'b0000, 4'b0000, 4'h3, regs[2]));
        tbl.push_back(mk(0, 4'b1111, 16'h4321, 4'hF, 4'b0000, 4'b0100, 4'h3, regs[3]));
        tbl.push_back(mk(0, 4'b1111, 16'h4321, 4'hF, 4'b1000, 4'b0000, 4'h3, regs[3]));
        tbl.push_back(mk(0, 4'b1111, 16'h4321, 4'hF, 4'b0000, 4'b0000, 4'h4, regs[3]));
        tbl.push_back(mk(0, 4'b1111, 16'h4321, 4'hF, 4'b0000, 4'b1000, 4'h4, regs[4]));
        tbl.push_back(mk(0, 4'b1111, 16'h4321, 4'hF, 4'b0001, 4'b0000, 4'h4, regs[4]));
        tbl.push_back(mk(0, 4'b1111, 16'h4321, 4'hF, 4'b0000, 4'b0000, 4'h1, regs[4]));
        tbl.push_back(mk(0, 4'b1111, 16'h4321, 4'hF, 4'b0000, 4'b0001, 4'h1, regs[1]));
        tbl.push_back(mk(0, 4'b0000, 16'h4321, 4'hF, 4'b0000, 4'b0000, 4'h1, regs[1]));
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].addr, tbl[i].rrdy);
            chk4($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_rv,
                 tbl[i].e_sel, tbl[i].e_data);
        end

        // backpressure on requester 2 for 5 cycles, others acking
        drive(1, 4'b0000, 16'h0, 4'b0000);
        drive(0, 4'b0100, 16'h0700, 4'b1111);
        chk4("bp_acc", 4'b0100, 4'b0000, 4'h0, 32'h0);
        drive(0, 4'b1011, 16'h0700, 4'b1111);
        chk4("bp_read", 4'b0000, 4'b0000, 4'h7, 32'h0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 4'b1011, 16'h0700, 4'b1011);
            chk4($sformatf("bp_hold%0d", k), 4'b0000, 4'b0100, 4'h7, regs[7]);
        end
        drive(0, 4'b1011, 16'h0700, 4'b0100);
        chk4("bp_done", 4'b0000, 4'b0100, 4'h7, regs[7]);
        drive(0, 4'b0000, 16'h0, 4'b0000);
        chk4("bp_idle", 4'b0000, 4'b0000, 4'h7, regs[7]);

        // requester 1 in RESP, wrong requester acks first
        drive(0, 4'b0010, 16'h0090, 4'b0000);
        chk4("wa_acc", 4'b0010, 4'b0000, 4'h7, regs[7]);
        drive(0, 4'b0000, 16'h0, 4'b0000);
        chk4("wa_read", 4'b0000, 4'b0000, 4'h9, regs[7]);
        for (int k = 0; k < 2; k++) begin
            drive(0, 4'b0000, 16'h0, 4'b0100);
            chk4($sformatf("wa_wrong%0d", k), 4'b0000, 4'b0010, 4'h9, regs[9]);
        end
        drive(0, 4'b0000, 16'h0, 4'b0010);
        chk4("wa_ack", 4'b0000, 4'b0010, 4'h9, regs[9]);
        drive(0, 4'b0000, 16'h0, 4'b0000);
        chk4("wa_idle", 4'b0000, 4'b0000, 4'h9, regs[9]);

        // reset pulse during READ aborts the read, ptr back to 0
        drive(0, 4'b0001, 16'h0006, 4'b1111);
        chk4("rm_acc", 4'b0001, 4'b0000, 4'h9, regs[9]);
        drive(1, 4'b0000, 16'h0, 4'b1111);
        chk4("rm_read", 4'b0000, 4'b0000, 4'h6, regs[9]);
        drive(0, 4'b0000, 16'h0, 4'b1111);
        chk4("rm_after", 4'b0000, 4'b0000, 4'h0, 32'h0);
        drive(0, 4'b1111, 16'h4321, 4'b1111);
        chk4("rm_regrant", 4'b0001, 4'b0000, 4'h0, 32'h0);
        drive(0, 4'b0000, 16'h0, 4'b1111);
        chk4("rm_read2", 4'b0000, 4'b0000, 4'h1, 32'h0);
        drive(0, 4'b0000, 16'h0, 4'b1111);
        chk4("rm_rsp", 4'b0000, 4'b0001, 4'h1, regs[1]);
        drive(0, 4'b0000, 16'h0, 4'b0000);
        chk4("rm_idle", 4'b0000, 4'b0000, 4'h1, regs[1]);

        // requester 1 pulses valid while busy, requester 2 waits
        drive(0, 4'b0001, 16'h0002, 4'b0000);
        chk4("wd_acc", 4'b0001, 4'b0000, 4'h1, regs[1]);
        drive(0, 4'b0110, 16'h0382, 4'b0000);
        chk4("wd_read", 4'b0000, 4'b0000, 4'h2, regs[1]);
        drive(0, 4'b0100, 16'h0300, 4'b1111);
        chk4("wd_rsp", 4'b0000, 4'b0001, 4'h2, regs[2]);
        drive(0, 4'b0100, 16'h0300, 4'b1111);
        chk4("wd_next", 4'b0100, 4'b0000, 4'h2, regs[2]);
        drive(0, 4'b0000, 16'h0, 4'b1111);
        chk4("wd_read2", 4'b0000, 4'b0000, 4'h3, regs[2]);
        drive(0, 4'b0000, 16'h0, 4'b1111);
        chk4("wd_rsp2", 4'b0000, 4'b0100, 4'h3, regs[3]);

        // random traffic vs transaction-level model
        owner = -1; since = 0; ptr = 0;
        maddr = '0; msel = '0; mdata = '0;
        for (int c = 0; c < 3000; c++) begin
            r  = (c == 0) || ($urandom_range(0, 63) == 0);
            v  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            a  = 16'($urandom);
            rr = 4'($urandom);
            drive(r, v, a, rr);
            e_rdy = '0;
            e_rv  = '0;
            win   = -1;
            if (owner < 0) begin
                for (int k = 0; k < 4; k++) begin
                    j = (ptr + k) % 4;
                    if (win < 0 && v[j]) win = j;
                end
                if (win >= 0 && !r) e_rdy = 4'(1 << win);
            end else if (since >= 2) begin
                e_rv = 4'(1 << owner);
            end
            if (c > 0) begin
                chk4($sformatf("rnd%0d", c), e_rdy, e_rv, msel, mdata);
            end
            if (r) begin
                owner = -1; ptr = 0; msel = '0; mdata = '0;
            end else if (owner < 0) begin
                if (win >= 0) begin
                    owner = win;
                    maddr = 4'(a >> (win * 4));
                    msel  = maddr;
                    since = 1;
                end
            end else if (since == 1) begin
                mdata = regs[maddr];
                since = 2;
            end else if (rr[owner]) begin
                ptr   = (owner + 1) % 4;
                owner = -1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
